reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The module SHALL have parameter LOCK_FILT, default 1024, giving the number of consecutive synchronized-lock-high cycles needed before the hold phase starts (legal range 1..65535).
REQ-002 The module SHALL have parameter HOLD_CYCLES, default 256, giving the number of extra reset-hold cycles after the lock filter passes (legal range 1..65535).
REQ-003 The module SHALL have parameter CE_DIV, default 2, giving the pixel clock-enable period in clk cycles (legal range 1..255).
REQ-004 Port clk, input, 1 bit: the PLL output clock (clkout), the single clock of the block.
REQ-005 Port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port lock, input, 1 bit: PLL lock indication, treated as asynchronous to clk.
REQ-007 Port clr_stat, input, 1 bit: synchronous single-cycle pulse that clears the statistics outputs.
REQ-008 Port rst_out_n, output, 1 bit: registered active-low reset for downstream logic.
REQ-009 Port ready, output, 1 bit: high exactly while the state is RUN.
REQ-010 Port ce_pix, output, 1 bit: registered pixel clock-enable strobe.
REQ-011 Port lock_lost, output, 1 bit: sticky flag, set on any lock loss during RUN.
REQ-012 Port loss_cnt, output, 8 bits: saturating count of lock losses during RUN.

Function
REQ-013 The lock input SHALL pass through a 2-flop synchronizer; the result is lock_s, and all decisions below use lock_s only.
REQ-014 The state machine SHALL have four states: WAIT_LOCK, FILTER, HOLD, RUN, plus one 16-bit counter cnt.
- WAIT_LOCK: if lock_s=1, go to FILTER with cnt=0.
- FILTER: cnt increments each cycle; if lock_s=0, go to WAIT_LOCK; if lock_s=1 and cnt==LOCK_FILT-1, go to HOLD with cnt=0.
- HOLD: cnt increments each cycle; if lock_s=0, go to WAIT_LOCK; if lock_s=1 and cnt==HOLD_CYCLES-1, go to RUN.
- RUN: if lock_s=0, go to WAIT_LOCK.
REQ-015 In every non-RUN state, cnt SHALL clear on any transition to WAIT_LOCK, so a lock glitch fully restarts filtering.
REQ-016 rst_out_n SHALL go high on the same clock edge on which the state enters RUN, and low on the same edge on which the state leaves RUN; it is never combinational.
REQ-017 Latency: with lock rising before edge 1 and held high, rst_out_n SHALL rise at edge 3+LOCK_FILT+HOLD_CYCLES.
REQ-018 Latency: with lock falling during RUN, rst_out_n SHALL fall at the 3rd edge after the fall.
REQ-019 A divider counter div SHALL be held at 0 outside RUN; in RUN it counts 0..CE_DIV-1 and wraps to 0.
REQ-020 ce_pix SHALL be high in a cycle exactly when rst_out_n=1 and div==0.
- The first strobe coincides with the first cycle rst_out_n is high, then every CE_DIV cycles.
- With CE_DIV=1, ce_pix is constantly high in RUN.
REQ-021 On a RUN->WAIT_LOCK transition, lock_lost SHALL set to 1 and loss_cnt SHALL increment, saturating at 255.
- Losses in FILTER or HOLD do not count.
REQ-022 clr_stat=1 SHALL clear lock_lost and loss_cnt on the next edge.
- If a loss event occurs on that same edge, the result is loss_cnt=1 and lock_lost=1.
REQ-023 ce_pix SHALL go low on the same edge on which rst_out_n falls.

Reset
REQ-024 Asserting resetn low SHALL immediately, without a clock, force the following, at any time including mid-HOLD or in RUN:
- state=WAIT_LOCK, cnt=0, div=0, synchronizer flops=0;
- rst_out_n=0, ready=0, ce_pix=0, lock_lost=0, loss_cnt=0.
REQ-025 After resetn rises, the sequence of REQ-017 SHALL restart from edge 1, even if lock is already high.

Verification (LOCK_FILT=4, HOLD_CYCLES=3, CE_DIV=2)
REQ-026 Lock high from edge 1 -> rst_out_n=0 through edge 9, rst_out_n=1 and ready=1 at edge 10, ce_pix=1 at edges 10,12,14; ce_pix=0 at edges 11,13.
REQ-027 Lock high 3 cycles, low 1 cycle, then high -> state returns to WAIT_LOCK with no rst_out_n rise; rst_out_n rises 3+4+3 edges after the second rise; loss_cnt=0.
REQ-028 Lock drop in RUN -> rst_out_n=0, ready=0, ce_pix=0 at the 3rd edge; lock_lost=1, loss_cnt=1; re-lock restarts the full 10-edge sequence.
REQ-029 300 RUN lock-loss cycles -> loss_cnt saturates at 255; clr_stat coinciding with a loss edge -> loss_cnt=1, lock_lost=1.
REQ-030 resetn pulsed low mid-HOLD and again in RUN -> all outputs 0 asynchronously (before the next edge); after release with lock held high, rst_out_n rises at edge 10.

Source files
------------

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Generates a clean downstream reset from a PLL lock signal.
//               The lock input is synchronized, must stay high for LOCK_FILT
//               cycles (filter) and a further HOLD_CYCLES cycles (hold)
//               before the design enters RUN and releases rst_out_n. In RUN
//               a pixel clock-enable strobe is generated every CE_DIV
//               cycles. Lock losses while running are recorded in a sticky
//               flag and a saturating counter.
// Ports       : clk       - PLL output clock, sole clock of the block
//               resetn    - asynchronous active-low reset
//               lock      - PLL lock, asynchronous to clk
//               clr_stat  - single-cycle pulse clearing lock_lost/loss_cnt
//               rst_out_n - registered active-low downstream reset
//               ready     - high while in RUN
//               ce_pix    - registered pixel clock-enable strobe
//               lock_lost - sticky lock-loss-in-RUN flag
//               loss_cnt  - saturating count of lock losses in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int LOCK_FILT   = 1024,
    parameter int HOLD_CYCLES = 256,
    parameter int CE_DIV      = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       lock,
    input  logic       clr_stat,
    output logic       rst_out_n,
    output logic       ready,
    output logic       ce_pix,
    output logic       lock_lost,
    output logic [7:0] loss_cnt
);

    localparam logic [15:0] c_filt_last = 16'(LOCK_FILT - 1);
    localparam logic [15:0] c_hold_last = 16'(HOLD_CYCLES - 1);
    localparam logic [7:0]  c_div_last  = 8'(CE_DIV - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Synchronizer
    logic r_sync1;
    logic r_lock_s;

    // Sequencer state
    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic [7:0]  r_div;
    logic [7:0]  w_div_next;

    // Registered outputs and their next values
    logic       r_rst_out_n;
    logic       r_ce_pix;
    logic       r_lock_lost;
    logic [7:0] r_loss_cnt;
    logic       w_loss_event;
    logic       w_lock_lost_next;
    logic [7:0] w_loss_base;
    logic [7:0] w_loss_cnt_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1     <= 1'b0;
            r_lock_s    <= 1'b0;
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_div       <= '0;
            r_rst_out_n <= 1'b0;
            r_ce_pix    <= 1'b0;
            r_lock_lost <= 1'b0;
            r_loss_cnt  <= '0;
        end else begin
            r_sync1     <= lock;
            r_lock_s    <= r_sync1;
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_div       <= w_div_next;
            // Outputs are registered from next-state values so they change
            // on the same edge the state enters or leaves RUN.
            r_rst_out_n <= (w_state_next == RUN);
            r_ce_pix    <= (w_state_next == RUN) && (w_div_next == 8'd0);
            r_lock_lost <= w_lock_lost_next;
            r_loss_cnt  <= w_loss_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_div_next   = 8'd0;

        case (r_state)
            WAIT_LOCK: begin
                w_cnt_next = '0;
                if (r_lock_s) begin
                    w_state_next = FILTER;
                end
            end
            FILTER: begin
                if (!r_lock_s) begin
                    w_state_next = WAIT_LOCK;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_filt_last) begin
                    w_state_next = HOLD;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            HOLD: begin
                if (!r_lock_s) begin
                    w_state_next = WAIT_LOCK;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_hold_last) begin
                    w_state_next = RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            RUN: begin
                w_cnt_next = '0;
                if (!r_lock_s) begin
                    w_state_next = WAIT_LOCK;
                end
            end
            default: begin
                w_state_next = WAIT_LOCK;
                w_cnt_next   = '0;
            end
        endcase

        // Divider restarts at 0 on RUN entry so the first strobe lines up
        // with the first released-reset cycle.
        if ((r_state == RUN) && (w_state_next == RUN)) begin
            w_div_next = (r_div == c_div_last) ? 8'd0 : (r_div + 8'd1);
        end
    end

    // Clear is applied first, so a loss on the clearing edge leaves a count of 1.
    always_comb begin
        w_loss_event     = (r_state == RUN) && (w_state_next != RUN);
        w_loss_base      = clr_stat ? 8'd0 : r_loss_cnt;
        w_loss_cnt_next  = w_loss_base;
        w_lock_lost_next = r_lock_lost & ~clr_stat;
        if (w_loss_event) begin
            w_lock_lost_next = 1'b1;
            if (w_loss_base != 8'hFF) begin
                w_loss_cnt_next = w_loss_base + 8'd1;
            end
        end
    end

    assign rst_out_n = r_rst_out_n;
    assign ready     = (r_state == RUN);
    assign ce_pix    = r_ce_pix;
    assign lock_lost = r_lock_lost;
    assign loss_cnt  = r_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Self-checking bench for reset_sequencer (LOCK_FILT=4,
//               HOLD_CYCLES=3, CE_DIV=2). A reference model tracks how long
//               the synchronized lock has been continuously high and derives
//               reset release, strobe phase and loss statistics from that.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int LOCK_FILT   = 4;
    localparam int HOLD_CYCLES = 3;
    localparam int CE_DIV      = 2;
    localparam int RISE_EDGE   = 3 + LOCK_FILT + HOLD_CYCLES;

    logic       clk;
    logic       resetn;
    logic       lock;
    logic       clr_stat;
    logic       rst_out_n;
    logic       ready;
    logic       ce_pix;
    logic       lock_lost;
    logic [7:0] loss_cnt;

    int n_cmp;
    int n_err;

    // Reference model state
    bit m_s1, m_s2;
    int m_high;
    bit m_run;
    int m_runlen;
    bit m_ce;
    bit m_lost;
    int m_loss;

    reset_sequencer #(
        .LOCK_FILT  (LOCK_FILT),
        .HOLD_CYCLES(HOLD_CYCLES),
        .CE_DIV     (CE_DIV)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .lock     (lock),
        .clr_stat (clr_stat),
        .rst_out_n(rst_out_n),
        .ready    (ready),
        .ce_pix   (ce_pix),
        .lock_lost(lock_lost),
        .loss_cnt (loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_s1 = 0; m_s2 = 0; m_high = 0; m_run = 0; m_runlen = 0;
        m_ce = 0; m_lost = 0; m_loss = 0;
    endtask

    // Released reset requires lock_s high on LOCK_FILT+HOLD_CYCLES+1
    // consecutive edges (one to leave WAIT_LOCK, then filter and hold).
    task automatic model_edge(input bit lk, input bit clr);
        bit ls;
        bit was_run;
        ls      = m_s2;
        was_run = m_run;
        m_s2    = m_s1;
        m_s1    = lk;
        m_high  = ls ? m_high + 1 : 0;
        m_run   = (m_high >= LOCK_FILT + HOLD_CYCLES + 1);
        m_runlen = m_run ? m_runlen + 1 : 0;
        m_ce    = m_run && (((m_runlen - 1) % CE_DIV) == 0);
        if (clr) begin
            m_lost = 0;
            m_loss = 0;
        end
        if (was_run && !m_run) begin
            m_lost = 1;
            if (m_loss < 255) m_loss++;
        end
    endtask

    // One clock edge: capture inputs, advance model, check all outputs 1 ns later.
    task automatic step();
        bit lk, cl;
        lk = lock;
        cl = clr_stat;
        @(posedge clk);
        model_edge(lk, cl);
        #1;
        check("rst_out_n", 32'(rst_out_n), 32'(m_run));
        check("ready",     32'(ready),     32'(m_run));
        check("ce_pix",    32'(ce_pix),    32'(m_ce));
        check("lock_lost", 32'(lock_lost), 32'(m_lost));
        check("loss_cnt",  32'(loss_cnt),  32'(m_loss));
    endtask

    // Asynchronous reset pulse between edges; outputs must drop before any edge.
    task automatic async_reset(input string tag);
        #3;
        resetn = 1'b0;
        #1;
        check({tag, "_rst_out_n"}, 32'(rst_out_n), 0);
        check({tag, "_ready"},     32'(ready),     0);
        check({tag, "_ce_pix"},    32'(ce_pix),    0);
        check({tag, "_lock_lost"}, 32'(lock_lost), 0);
        check({tag, "_loss_cnt"},  32'(loss_cnt),  0);
        model_clear();
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
    endtask

    // Lock held high from edge 1: explicit release edge and strobe pattern.
    task automatic seq_check(input string tag, input int rise);
        for (int e = 1; e <= rise + 4; e++) begin
            step();
            check({tag, "_rst"}, 32'(rst_out_n), 32'(e >= rise));
            check({tag, "_ce"},  32'(ce_pix),
                  32'((e >= rise) && (((e - rise) % CE_DIV) == 0)));
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        resetn   = 1'b0;
        lock     = 1'b0;
        clr_stat = 1'b0;
        model_clear();
        #2;
        check("reset_rst_out_n", 32'(rst_out_n), 0);
        check("reset_ready",     32'(ready),     0);
        check("reset_ce_pix",    32'(ce_pix),    0);
        check("reset_loss_cnt",  32'(loss_cnt),  0);
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        lock   = 1'b1;

        // Basic lock-up sequence
        seq_check("seq26", RISE_EDGE);

        // Drop lock in RUN: reset falls on the 3rd edge, loss recorded
        lock = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            check("drop_rst", 32'(rst_out_n), 32'(e < 3));
        end
        check("drop_lost", 32'(lock_lost), 1);
        check("drop_cnt",  32'(loss_cnt),  1);
        lock = 1'b1;
        seq_check("relock", RISE_EDGE);

        // Glitch during FILTER: no release, restart from the second rise
        async_reset("glitch_rst");
        for (int e = 1; e <= RISE_EDGE + 8; e++) begin
            lock = (e != 4);
            step();
            check("glitch_rst_out", 32'(rst_out_n), 32'(e >= 4 + RISE_EDGE));
        end
        check("glitch_loss", 32'(loss_cnt), 0);

        // Reset mid-HOLD, then again in RUN
        async_reset("pre_hold");
        lock = 1'b1;
        repeat (8) step();
        async_reset("mid_hold");
        seq_check("after_hold_rst", RISE_EDGE);
        async_reset("in_run");
        seq_check("after_run_rst", RISE_EDGE);

        // Saturation of the loss counter
        for (int i = 0; i < 300; i++) begin
            lock = 1'b1;
            repeat (RISE_EDGE + 1) step();
            lock = 1'b0;
            repeat (4) step();
        end
        check("sat_cnt",  32'(loss_cnt),  255);
        check("sat_lost", 32'(lock_lost), 1);

        // Clear coinciding with a loss edge
        lock = 1'b1;
        repeat (RISE_EDGE + 2) step();
        lock = 1'b0;
        step();
        step();
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        check("clr_loss_cnt",  32'(loss_cnt),  1);
        check("clr_loss_lost", 32'(lock_lost), 1);
        step();
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        check("clr_only_cnt",  32'(loss_cnt),  0);
        check("clr_only_lost", 32'(lock_lost), 0);

        // Randomized lock behaviour, occasional clears and resets
        for (int i = 0; i < 3000; i++) begin
            if (lock) lock = ($urandom_range(0, 24) != 0);
            else      lock = ($urandom_range(0, 2) == 0);
            clr_stat = ($urandom_range(0, 39) == 0);
            step();
            clr_stat = 1'b0;
            if ($urandom_range(0, 499) == 0) async_reset("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
